// File: rtl/sata_device_phy_layer_if.sv
// Bundle of the device phy's link-layer and transceiver-side signals.
// The phy uses the slave view; the driving side (link layer, transceiver
// wrapper, or a bench) uses the master view.
interface sata_device_phy_layer_if;
    logic        platform_ready;
    logic        platform_error;
    logic        linkup;
    logic [31:0] link_tx_dout;
    logic        link_tx_isk;
    logic [31:0] tx_dout;
    logic        tx_isk;
    logic        tx_comm_init;
    logic        tx_comm_wake;
    logic        tx_elec_idle;
    logic        tx_oob_complete;
    logic [31:0] rx_din;
    logic [3:0]  rx_isk;
    logic        rx_elec_idle;
    logic        comm_reset_detect;
    logic        comm_wake_detect;
    logic        phy_ready;
    logic        phy_error;
    logic [3:0]  lax_state;

    modport slave (
        input  platform_ready, link_tx_dout, link_tx_isk, tx_oob_complete,
               rx_din, rx_isk, rx_elec_idle, comm_reset_detect,
               comm_wake_detect, phy_error,
        output platform_error, linkup, tx_dout, tx_isk, tx_comm_init,
               tx_comm_wake, tx_elec_idle, phy_ready, lax_state
    );

    modport master (
        output platform_ready, link_tx_dout, link_tx_isk, tx_oob_complete,
               rx_din, rx_isk, rx_elec_idle, comm_reset_detect,
               comm_wake_detect, phy_error,
        input  platform_error, linkup, tx_dout, tx_isk, tx_comm_init,
               tx_comm_wake, tx_elec_idle, phy_ready, lax_state
    );
endinterface

// File: rtl/sata_device_phy_layer.sv
// Device-side SATA phy: answers the host OOB handshake, runs the
// ALIGN/SYNC negotiation, then muxes link-layer dwords onto the
// transceiver with an ALIGN pair inserted after every 256 link dwords.
module sata_device_phy_layer #(
    parameter logic [15:0] TIMEOUT = 16'd32768
) (
    input  logic                   clk,
    input  logic                   rst,
    sata_device_phy_layer_if.slave bus
);
    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        SEND_COMINIT = 4'd1,
        WAIT_COMWAKE = 4'd2,
        SEND_COMWAKE = 4'd3,
        SEND_ALIGN   = 4'd4,
        SEND_SYNC    = 4'd5,
        READY        = 4'd6,
        INS_ALIGN0   = 4'd7,
        INS_ALIGN1   = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  align_run_q, align_run_d;
    logic [1:0]  sync_run_q, sync_run_d;
    logic [7:0]  align_count_q, align_count_d;
    logic [15:0] timer_q, timer_d;
    logic        platform_error_q, platform_error_d;

    logic        rx_prim, rx_align, timing_state, timed_out, in_link;
    logic [31:0] tx_dout_c;
    logic        tx_isk_c, tx_comm_init_c, tx_comm_wake_c, tx_elec_idle_c;
    logic        phy_ready_c, linkup_c;
    logic        unused_inputs;

    // A decode/disparity error disqualifies the dword as a primitive.
    assign rx_prim       = bus.rx_isk[0] && !bus.phy_error;
    assign rx_align      = rx_prim && (bus.rx_din == PRIM_ALIGN);
    assign unused_inputs = ^{bus.rx_elec_idle, bus.rx_isk[3:1]};

    // State, run counters, ALIGN spacing counter, timeout timer, error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            align_run_q      <= 2'd0;
            sync_run_q       <= 2'd0;
            align_count_q    <= 8'd0;
            timer_q          <= 16'd0;
            platform_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            align_run_q      <= align_run_d;
            sync_run_q       <= sync_run_d;
            align_count_q    <= align_count_d;
            timer_q          <= timer_d;
            platform_error_q <= platform_error_d;
        end
    end

    // Next state: normal sequencing first, then timeout, host COMRESET
    // and loss of platform lock override it in rising priority.
    always_comb begin
        state_d          = state_q;
        align_run_d      = 2'd0;
        sync_run_d       = 2'd0;
        align_count_d    = align_count_q;
        timer_d          = 16'd0;
        platform_error_d = platform_error_q;
        timing_state     = (state_q == WAIT_COMWAKE) || (state_q == SEND_ALIGN) ||
                           (state_q == SEND_SYNC);
        timed_out        = timing_state && (timer_q == TIMEOUT - 16'd1);
        in_link          = (state_q == READY) || (state_q == INS_ALIGN0) ||
                           (state_q == INS_ALIGN1);

        case (state_q)
            IDLE:         if (bus.comm_reset_detect) state_d = SEND_COMINIT;
            SEND_COMINIT: begin
                platform_error_d = 1'b0;
                if (bus.tx_oob_complete) state_d = WAIT_COMWAKE;
            end
            WAIT_COMWAKE: if (bus.comm_wake_detect) state_d = SEND_COMWAKE;
            SEND_COMWAKE: if (bus.tx_oob_complete) state_d = SEND_ALIGN;
            SEND_ALIGN:   if (rx_align && align_run_q == 2'd2) state_d = SEND_SYNC;
            SEND_SYNC: begin
                if (rx_prim && !rx_align && sync_run_q == 2'd2) begin
                    state_d       = READY;
                    align_count_d = 8'd0;
                end
            end
            READY: begin
                align_count_d = align_count_q + 8'd1;
                if (align_count_q == 8'd255) state_d = INS_ALIGN0;
            end
            INS_ALIGN0:   state_d = INS_ALIGN1;
            INS_ALIGN1:   state_d = READY;
            default:      state_d = IDLE;
        endcase

        if (in_link && bus.phy_error) platform_error_d = 1'b1;

        if (!bus.platform_ready) begin
            state_d = IDLE;
        end else if (bus.comm_reset_detect) begin
            state_d = SEND_COMINIT;
        end else if (timed_out) begin
            state_d          = IDLE;
            platform_error_d = 1'b1;
        end

        // Run counters and timer only live while the state is held.
        if (state_d == state_q) begin
            if (state_q == SEND_ALIGN && rx_align)
                align_run_d = (align_run_q == 2'd3) ? 2'd3 : align_run_q + 2'd1;
            if (state_q == SEND_SYNC) begin
                if (rx_align)
                    sync_run_d = sync_run_q;
                else if (rx_prim)
                    sync_run_d = (sync_run_q == 2'd3) ? 2'd3 : sync_run_q + 2'd1;
            end
            if (timing_state) timer_d = timer_q + 16'd1;
        end
    end

    // Output decode from the current state (plus the link-data mux).
    always_comb begin
        tx_dout_c      = 32'd0;
        tx_isk_c       = 1'b0;
        tx_comm_init_c = 1'b0;
        tx_comm_wake_c = 1'b0;
        tx_elec_idle_c = 1'b0;
        phy_ready_c    = 1'b0;
        linkup_c       = 1'b0;
        case (state_q)
            IDLE, WAIT_COMWAKE: tx_elec_idle_c = 1'b1;
            SEND_COMINIT: begin
                tx_comm_init_c = 1'b1;
                tx_elec_idle_c = 1'b1;
            end
            SEND_COMWAKE: begin
                tx_comm_wake_c = 1'b1;
                tx_elec_idle_c = 1'b1;
            end
            SEND_ALIGN: begin
                tx_dout_c = PRIM_ALIGN;
                tx_isk_c  = 1'b1;
            end
            SEND_SYNC: begin
                tx_dout_c = PRIM_SYNC;
                tx_isk_c  = 1'b1;
            end
            READY: begin
                tx_dout_c   = bus.link_tx_dout;
                tx_isk_c    = bus.link_tx_isk;
                phy_ready_c = 1'b1;
                linkup_c    = 1'b1;
            end
            INS_ALIGN0, INS_ALIGN1: begin
                tx_dout_c = PRIM_ALIGN;
                tx_isk_c  = 1'b1;
                linkup_c  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.tx_dout        = tx_dout_c;
    assign bus.tx_isk         = tx_isk_c;
    assign bus.tx_comm_init   = tx_comm_init_c;
    assign bus.tx_comm_wake   = tx_comm_wake_c;
    assign bus.tx_elec_idle   = tx_elec_idle_c;
    assign bus.phy_ready      = phy_ready_c;
    assign bus.linkup         = linkup_c;
    assign bus.platform_error = platform_error_q;
    assign bus.lax_state      = state_q;
endmodule

// File: tb/tb_sata_device_phy_layer.sv
// Bench for sata_device_phy_layer: directed bring-up, ALIGN insertion,
// error and timeout scenarios, then randomized traffic, all compared
// against a phase-level model of the device phy.
module tb_sata_device_phy_layer;
    localparam int          TO    = 100;
    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5957C;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sata_device_phy_layer_if bus();

    sata_device_phy_layer #(.TIMEOUT(16'd100)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: m_st is the phase (0..5 handshake states, 6 = link phase),
    // m_pos the position inside the 258-dword link frame, m_arun/m_srun
    // the qualifying receive runs, m_time the cycles spent in the phase.
    int m_st = 0, m_arun = 0, m_srun = 0, m_time = 0, m_pos = 0, nst;
    bit m_err = 1'b0, al, pr;
    int ds;
    logic [31:0] e_dout;
    logic        e_isk;

    function automatic int disp_state();
        if (m_st != 6) return m_st;
        if (m_pos < 256) return 6;
        return (m_pos == 256) ? 7 : 8;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model, advanced on every rising edge.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_st = 0; m_err = 0; m_arun = 0; m_srun = 0; m_time = 0; m_pos = 0;
        end else begin
            pr  = bus.rx_isk[0] && !bus.phy_error;
            al  = pr && (bus.rx_din == ALIGN);
            nst = m_st;
            if (m_st == 6 && bus.phy_error) m_err = 1;
            if (m_st == 1) m_err = 0;
            case (m_st)
                0: if (bus.comm_reset_detect) nst = 1;
                1: if (bus.tx_oob_complete) nst = 2;
                2: if (bus.comm_wake_detect) nst = 3;
                3: if (bus.tx_oob_complete) nst = 4;
                4: if (al && m_arun + 1 == 3) nst = 5;
                5: if (pr && !al && m_srun + 1 == 3) nst = 6;
                default: ;
            endcase
            if (!bus.platform_ready) nst = 0;
            else if (bus.comm_reset_detect) nst = 1;
            else if ((m_st == 2 || m_st == 4 || m_st == 5) && m_time == TO - 1) begin
                nst = 0;
                m_err = 1;
            end
            if (nst != m_st) begin
                if (nst == 6) m_pos = 0;
                m_arun = 0; m_srun = 0; m_time = 0;
            end else begin
                m_time++;
                m_arun = al ? m_arun + 1 : 0;
                m_srun = al ? m_srun : (pr ? m_srun + 1 : 0);
                if (m_st == 6) m_pos = (m_pos + 1) % 258;
            end
            m_st = nst;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            ds = disp_state();
            e_dout = (ds == 4 || ds == 7 || ds == 8) ? ALIGN :
                     (ds == 5) ? SYNC : (ds == 6) ? bus.link_tx_dout : 32'd0;
            e_isk  = (ds == 4 || ds == 5 || ds == 7 || ds == 8) ? 1'b1 :
                     (ds == 6) ? bus.link_tx_isk : 1'b0;
            chk("lax_state", 32'(bus.lax_state), 32'(ds));
            chk("platform_error", 32'(bus.platform_error), 32'(m_err));
            chk("linkup", 32'(bus.linkup), 32'(ds >= 6));
            chk("phy_ready", 32'(bus.phy_ready), 32'(ds == 6));
            chk("tx_dout", bus.tx_dout, e_dout);
            chk("tx_isk", 32'(bus.tx_isk), 32'(e_isk));
            chk("tx_comm_init", 32'(bus.tx_comm_init), 32'(ds == 1));
            chk("tx_comm_wake", 32'(bus.tx_comm_wake), 32'(ds == 3));
            chk("tx_elec_idle", 32'(bus.tx_elec_idle), 32'(ds <= 3));
        end
    end

    task automatic set_rx(input logic [31:0] d, input logic [3:0] k);
        bus.rx_din = d;
        bus.rx_isk = k;
    endtask

    int rsel, ds_s, rlim;

    initial begin
        bus.platform_ready = 0; bus.link_tx_dout = 0; bus.link_tx_isk = 0;
        bus.tx_oob_complete = 0; bus.rx_din = 0; bus.rx_isk = 0;
        bus.rx_elec_idle = 0; bus.comm_reset_detect = 0;
        bus.comm_wake_detect = 0; bus.phy_error = 0;
        tick(); tick();
        chk_en = 1;
        rst = 0;
        chk("reset lax_state", 32'(bus.lax_state), 32'd0);
        chk("reset tx_elec_idle", 32'(bus.tx_elec_idle), 32'd1);
        chk("reset tx_dout", bus.tx_dout, 32'd0);

        // Bring-up.
        bus.platform_ready = 1; bus.comm_reset_detect = 1; tick();
        bus.comm_reset_detect = 0;
        chk("bringup comm_init", 32'(bus.tx_comm_init), 32'd1);
        bus.tx_oob_complete = 1; tick(); bus.tx_oob_complete = 0;
        chk("bringup wait_comwake", 32'(bus.lax_state), 32'd2);
        bus.comm_wake_detect = 1; tick(); bus.comm_wake_detect = 0;
        chk("bringup comm_wake", 32'(bus.tx_comm_wake), 32'd1);
        bus.tx_oob_complete = 1; tick(); bus.tx_oob_complete = 0;
        chk("bringup align dout", bus.tx_dout, 32'h7B4A4ABC);
        chk("bringup align isk", 32'(bus.tx_isk), 32'd1);
        set_rx(ALIGN, 4'b0001);
        repeat (3) tick();
        chk("bringup sync dout", bus.tx_dout, 32'hB5B5957C);
        set_rx(SYNC, 4'b0001);
        bus.link_tx_dout = 32'h12345678;
        repeat (3) tick();
        set_rx(32'd0, 4'd0);
        chk("bringup phy_ready", 32'(bus.phy_ready), 32'd1);
        chk("bringup linkup", 32'(bus.linkup), 32'd1);
        chk("bringup lax_state", 32'(bus.lax_state), 32'd6);

        // ALIGN insertion over two 258-dword frames.
        for (int i = 0; i < 516; i++) begin
            chk("insert dout", bus.tx_dout, ((i % 258) < 256) ? 32'h12345678 : 32'h7B4A4ABC);
            chk("insert phy_ready", 32'(bus.phy_ready), ((i % 258) < 256) ? 32'd1 : 32'd0);
            tick();
        end

        // phy_error while ready.
        bus.phy_error = 1; tick(); bus.phy_error = 0;
        chk("phyerr platform_error", 32'(bus.platform_error), 32'd1);
        chk("phyerr still ready", 32'(bus.lax_state), 32'd6);

        // Host COMRESET while ready.
        bus.comm_reset_detect = 1; tick(); bus.comm_reset_detect = 0;
        chk("hostrst lax_state", 32'(bus.lax_state), 32'd1);
        chk("hostrst linkup", 32'(bus.linkup), 32'd0);
        chk("hostrst phy_ready", 32'(bus.phy_ready), 32'd0);
        chk("hostrst comm_init", 32'(bus.tx_comm_init), 32'd1);
        tick();
        chk("hostrst error cleared", 32'(bus.platform_error), 32'd0);

        // Broken ALIGN run.
        bus.tx_oob_complete = 1; tick(); bus.tx_oob_complete = 0;
        bus.comm_wake_detect = 1; tick(); bus.comm_wake_detect = 0;
        bus.tx_oob_complete = 1; tick(); bus.tx_oob_complete = 0;
        set_rx(ALIGN, 4'b0001); tick(); tick();
        set_rx(32'h4A4A4A4A, 4'b0000); tick();
        set_rx(ALIGN, 4'b0001); tick();
        chk("broken run stays", 32'(bus.lax_state), 32'd4);
        tick(); tick();
        chk("broken run recovers", 32'(bus.lax_state), 32'd5);
        set_rx(32'd0, 4'd0);

        // Synchronous reset during SEND_SYNC.
        rst = 1; tick(); rst = 0;
        chk("rst lax_state", 32'(bus.lax_state), 32'd0);
        chk("rst tx_elec_idle", 32'(bus.tx_elec_idle), 32'd1);
        chk("rst tx_isk", 32'(bus.tx_isk), 32'd0);

        // Timeout in WAIT_COMWAKE.
        bus.comm_reset_detect = 1; tick(); bus.comm_reset_detect = 0;
        bus.tx_oob_complete = 1; tick(); bus.tx_oob_complete = 0;
        chk("timeout entry", 32'(bus.lax_state), 32'd2);
        repeat (TO - 1) tick();
        chk("timeout not yet", 32'(bus.lax_state), 32'd2);
        tick();
        chk("timeout idle", 32'(bus.lax_state), 32'd0);
        chk("timeout error", 32'(bus.platform_error), 32'd1);
        bus.comm_reset_detect = 1; tick(); bus.comm_reset_detect = 0;
        chk("timeout cominit", 32'(bus.lax_state), 32'd1);
        tick();
        chk("timeout error cleared", 32'(bus.platform_error), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 20000; i++) begin
            ds_s = disp_state();
            rst  = ($urandom_range(0, 2999) == 0);
            bus.platform_ready = ($urandom_range(0, 799) != 0);
            rlim = (ds_s == 0) ? 9 : 2999;
            bus.comm_reset_detect = bus.platform_ready && ($urandom_range(0, rlim) == 0);
            bus.comm_wake_detect  = ($urandom_range(0, 5) == 0);
            bus.tx_oob_complete   = ($urandom_range(0, 3) == 0);
            bus.phy_error         = ($urandom_range(0, 39) == 0);
            bus.rx_elec_idle      = 1'($urandom);
            bus.link_tx_dout      = $urandom;
            bus.link_tx_isk       = 1'($urandom);
            rsel = $urandom_range(0, 19);
            if (rsel < 12)      set_rx(ALIGN, {3'($urandom), 1'b1});
            else if (rsel < 17) set_rx(SYNC, {3'($urandom), 1'b1});
            else if (rsel < 19) set_rx($urandom, {3'($urandom), 1'b0});
            else                set_rx($urandom, {3'($urandom), 1'b1});
            tick();
        end

        rst = 1; tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
